// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, condition functions, status codes
// and the condition-code record used by the execute stage.
package y86_pkg;

    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] ICMOV = 4'h2;
    localparam logic [3:0] IOPQ  = 4'h6;
    localparam logic [3:0] IJXX  = 4'h7;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
        logic cf;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0, cf: 1'b0};

endpackage

// File: rtl/exec_cc_mreg_cond_eval.sv
// Y86 branch/cmov condition evaluator; purely combinational so decode-stage
// predictor checks can share it.
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic less;

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        less = sf ^ of;
        cnd  = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = less | zf;
            C_L:      cnd = less;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~less;
            C_G:      cnd = ~less & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cc_mreg.sv
// Execute-stage back end: condition-code register, Cnd evaluation, cmov
// destination squash and the E->M pipeline register.
module exec_cc_mreg
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] alu_out,
    input  logic         alu_carry_out,
    input  logic         alu_overflow_check,
    input  logic [2:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic         exc_block,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of,
    output logic         cc_cf,
    output logic         e_cnd,
    output logic [3:0]   e_dstE,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    typedef struct packed {
        logic [2:0]   stat;
        logic [3:0]   icode;
        logic         cnd;
        logic [W-1:0] valE;
        logic [W-1:0] valA;
        logic [3:0]   dstE;
        logic [3:0]   dstM;
    } mreg_t;

    localparam mreg_t M_NOP = '{
        stat:  AOK,
        icode: INOP,
        cnd:   1'b0,
        valE:  '0,
        valA:  '0,
        dstE:  RNONE,
        dstM:  RNONE
    };

    cc_t   cc_d, cc_q;
    mreg_t m_d, m_q;
    logic  cc_upd;

    // A stalled M stage means the OPq in E will be replayed, so it must not
    // commit flags yet; a later-stage exception means it must never commit.
    assign cc_upd = (E_icode == IOPQ) && !exc_block && !M_stall && (E_stat == AOK);

    always_comb begin
        cc_d = cc_q;
        if (cc_upd) begin
            cc_d.zf = (alu_out == '0);
            cc_d.sf = alu_out[W-1];
            cc_d.of = alu_overflow_check;
            cc_d.cf = alu_carry_out;
        end
    end

    cond_eval u_cond_eval (
        .ifun (E_ifun),
        .zf   (cc_q.zf),
        .sf   (cc_q.sf),
        .of   (cc_q.of),
        .cnd  (e_cnd)
    );

    always_comb begin
        e_dstE = E_dstE;
        if ((E_icode == ICMOV) && !e_cnd) begin
            e_dstE = RNONE;
        end
    end

    always_comb begin
        m_d = m_q;
        if (!M_stall) begin
            if (M_bubble) begin
                m_d = M_NOP;
            end else begin
                m_d.stat  = E_stat;
                m_d.icode = E_icode;
                m_d.cnd   = e_cnd;
                m_d.valE  = alu_out;
                m_d.valA  = E_valA;
                m_d.dstE  = e_dstE;
                m_d.dstM  = E_dstM;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator runs the blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= CC_RESET;
            m_q  <= M_NOP;
        end else begin
            cc_q <= cc_d;
            m_q  <= m_d;
        end
    end

    assign cc_zf   = cc_q.zf;
    assign cc_sf   = cc_q.sf;
    assign cc_of   = cc_q.of;
    assign cc_cf   = cc_q.cf;

    assign M_stat  = m_q.stat;
    assign M_icode = m_q.icode;
    assign M_cnd   = m_q.cnd;
    assign M_valE  = m_q.valE;
    assign M_valA  = m_q.valA;
    assign M_dstE  = m_q.dstE;
    assign M_dstM  = m_q.dstM;

endmodule

// File: tb/tb_exec_cc_mreg.sv
// Self-checking bench for exec_cc_mreg: a flag/M-register model feeds a
// scoreboard queue that is drained after each clock edge.
module tb_exec_cc_mreg;
    import y86_pkg::*;

    localparam int W = 64;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } exp_m_t;

    localparam exp_m_t EXP_NOP = '{stat: 3'd1, icode: 4'd1, cnd: 1'b0,
                                   valE: 64'd0, valA: 64'd0, dstE: 4'hF, dstM: 4'hF};

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] alu_out = '0;
    logic         alu_carry_out = 1'b0;
    logic         alu_overflow_check = 1'b0;
    logic [2:0]   E_stat = 3'd1;
    logic [3:0]   E_icode = 4'd1;
    logic [3:0]   E_ifun = 4'd0;
    logic [W-1:0] E_valA = '0;
    logic [3:0]   E_dstE = 4'hF;
    logic [3:0]   E_dstM = 4'hF;
    logic         exc_block = 1'b0;
    logic         M_stall = 1'b0;
    logic         M_bubble = 1'b1;
    logic         cc_zf, cc_sf, cc_of, cc_cf, e_cnd;
    logic [3:0]   e_dstE;
    logic [2:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE, M_valA;
    logic [3:0]   M_dstE, M_dstM;

    exec_cc_mreg #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out),
        .alu_overflow_check(alu_overflow_check),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .exc_block(exc_block),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .cc_cf(cc_cf),
        .e_cnd(e_cnd), .e_dstE(e_dstE),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    logic   mzf = 1'b1, msf = 1'b0, mof = 1'b0, mcf = 1'b0;
    exp_m_t m_last = EXP_NOP;
    exp_m_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_cnd(input logic [3:0] f, input logic zf, input logic sf,
                                       input logic of);
        logic lt;
        lt = (sf != of);
        case (f)
            4'd0:    return 1'b1;
            4'd1:    return lt || zf;
            4'd2:    return lt;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !lt;
            4'd6:    return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_cc(input string tag);
        check({tag, ".zf"}, cc_zf, mzf);
        check({tag, ".sf"}, cc_sf, msf);
        check({tag, ".of"}, cc_of, mof);
        check({tag, ".cf"}, cc_cf, mcf);
    endtask

    task automatic check_nop_now(input string tag);
        check({tag, ".M_stat"}, M_stat, 64'd1);
        check({tag, ".M_icode"}, M_icode, 64'd1);
        check({tag, ".M_cnd"}, M_cnd, 64'd0);
        check({tag, ".M_valE"}, M_valE, 64'd0);
        check({tag, ".M_valA"}, M_valA, 64'd0);
        check({tag, ".M_dstE"}, M_dstE, 64'hF);
        check({tag, ".M_dstM"}, M_dstM, 64'hF);
        check({tag, ".cc_zf"}, cc_zf, 64'd1);
        check({tag, ".cc_sf"}, cc_sf, 64'd0);
        check({tag, ".cc_of"}, cc_of, 64'd0);
        check({tag, ".cc_cf"}, cc_cf, 64'd0);
    endtask

    // One pipeline cycle: drive E, check combinational outputs, predict M and
    // the flags, clock, then compare against the scoreboard.
    task automatic cycle(input string tag, input logic [2:0] stat, input logic [3:0] icode,
                         input logic [3:0] ifun, input logic [63:0] alu,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                         input logic ovf, input logic cy, input logic exc,
                         input logic stall, input logic bubble);
        logic   ecnd;
        logic   [3:0] edst;
        logic   upd;
        exp_m_t nx, got;
        E_stat = stat; E_icode = icode; E_ifun = ifun; alu_out = alu; E_valA = va;
        E_dstE = de; E_dstM = dm; alu_overflow_check = ovf; alu_carry_out = cy;
        exc_block = exc; M_stall = stall; M_bubble = bubble;
        #1;
        ecnd = model_cnd(ifun, mzf, msf, mof);
        edst = (icode == 4'd2 && !ecnd) ? 4'hF : de;
        check({tag, ".e_cnd"}, e_cnd, ecnd);
        check({tag, ".e_dstE"}, e_dstE, edst);
        if (stall)       nx = m_last;
        else if (bubble) nx = EXP_NOP;
        else             nx = '{stat: stat, icode: icode, cnd: ecnd, valE: alu, valA: va,
                                dstE: edst, dstM: dm};
        sb_q.push_back(nx);
        m_last = nx;
        upd = (icode == 4'd6) && !exc && !stall && (stat == 3'd1);
        @(posedge clk);
        #1;
        if (upd) begin
            mzf = (alu == 64'd0); msf = alu[63]; mof = ovf; mcf = cy;
        end
        check_cc(tag);
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            check({tag, ".M_stat"}, M_stat, got.stat);
            check({tag, ".M_icode"}, M_icode, got.icode);
            check({tag, ".M_cnd"}, M_cnd, got.cnd);
            check({tag, ".M_valE"}, M_valE, got.valE);
            check({tag, ".M_valA"}, M_valA, got.valA);
            check({tag, ".M_dstE"}, M_dstE, got.dstE);
            check({tag, ".M_dstM"}, M_dstM, got.dstM);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] icodes [4];
        icodes[0] = 4'd2; icodes[1] = 4'd6; icodes[2] = 4'd7; icodes[3] = 4'd3;

        // Reset with the clock stopped.
        #1 rst = 1'b1;
        #2;
        check_nop_now("reset");
        rst = 1'b0;
        #1 clk_en = 1'b1;
        @(posedge clk);
        #1;

        // Flag tracking: nonzero positive, then zero, then -1 with overflow.
        cycle("opq_pos", AOK, IOPQ, 4'd0, 64'd5, 64'd0, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("opq_zero", AOK, IOPQ, 4'd1, 64'd0, 64'd9, 4'h2, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("je_taken", AOK, IJXX, C_E, 64'h40, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("opq_neg1", AOK, IOPQ, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'h1, 4'hF,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("jl", AOK, IJXX, C_L, 64'h80, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("jge", AOK, IJXX, C_GE, 64'h88, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Most negative value: SF=1, ZF=0.
        cycle("opq_min", AOK, IOPQ, 4'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h4, 4'hF,
              1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("jle", AOK, IJXX, C_LE, 64'h90, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("jg", AOK, IJXX, C_G, 64'h98, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // cmov squash with ZF=0.
        cycle("opq_7", AOK, IOPQ, 4'd0, 64'd7, 64'd0, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("cmove", AOK, ICMOV, C_E, 64'hAB, 64'hAB, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("cmovne", AOK, ICMOV, C_NE, 64'hCD, 64'hCD, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Exception blocking: M loads, flags frozen.
        cycle("exc_blk", AOK, IOPQ, 4'd0, 64'd0, 64'd1, 4'h6, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("hlt_opq", HLT, IOPQ, 4'd0, 64'd0, 64'd2, 4'h6, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stall, bubble, stall+bubble.
        cycle("pre_stall", AOK, IOPQ, 4'd2, 64'h1234, 64'h77, 4'h7, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("stall1", AOK, IOPQ, 4'd0, 64'd0, 64'h11, 4'h1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("stall2", AOK, IJXX, 4'd3, 64'h22, 64'h22, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("bubble", AOK, IOPQ, 4'd0, 64'h33, 64'h33, 4'h3, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("reload", AOK, IOPQ, 4'd0, 64'h44, 64'h44, 4'h4, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("stall_bub", AOK, IOPQ, 4'd0, 64'd0, 64'h55, 4'h5, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Mixed traffic, including undefined condition functions.
        for (int i = 0; i < 24; i++) begin
            logic [63:0] a;
            a = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
            cycle("rand", ($urandom_range(0, 4) == 0) ? HLT : AOK,
                  icodes[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), a,
                  {$urandom(), $urandom()}, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        // Async reset while M holds OPq data under stall.
        cycle("ld_opq", AOK, IOPQ, 4'd0, 64'h55, 64'h66, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("hold_opq", AOK, IOPQ, 4'd0, 64'd0, 64'h0, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_nop_now("async_rst");
        rst = 1'b0;
        mzf = 1'b1; msf = 1'b0; mof = 1'b0; mcf = 1'b0;
        m_last = EXP_NOP;
        cycle("post_rst_hold", AOK, IOPQ, 4'd0, 64'd9, 64'd9, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("post_rst", AOK, IJXX, C_E, 64'h10, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_cc_mreg.md
Name: exec_cc_mreg

Overview:
- Execute-stage back end that sits directly downstream of the 64-bit ALU.
- Registers the Y86 condition codes (ZF, SF, OF, plus CF for debug) from the ALU result and flags.
- Evaluates the branch/cmov condition (Cnd) from the registered codes.
- Latches the E->M pipeline register, with stall and bubble control from the pipeline control logic.

Parameters:
- W, 64, datapath width.
- RNONE, 4'hF, "no register" destination code.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset
- alu_out  in  W  ALU result
- alu_carry_out  in  1  ALU carry
- alu_overflow_check  in  1  ALU signed overflow
- E_stat  in  3  status of the instruction in E
- E_icode  in  4  icode in E
- E_ifun  in  4  ifun in E
- E_valA  in  W  valA in E
- E_dstE  in  4  dstE in E
- E_dstM  in  4  dstM in E
- exc_block  in  1  a later stage (m_stat or W_stat) holds an exception; suppress the CC update
- M_stall  in  1  hold the M register
- M_bubble  in  1  load a NOP into the M register
- cc_zf, cc_sf, cc_of, cc_cf  out  1 each  registered condition codes
- e_cnd  out  1  combinational condition result
- e_dstE  out  4  dstE after the cmov squash (forwarding source)
- M_stat  out  3  M register field
- M_icode  out  4  M register field
- M_cnd  out  1  M register field
- M_valE  out  W  M register field
- M_valA  out  W  M register field
- M_dstE  out  4  M register field
- M_dstM  out  4  M register field

Interface: one clock; reset is asynchronous and active-high. Clock is clk, reset is rst.

Behaviour:
- Reset (async, takes effect immediately, independent of clk):
  - cc_zf=1, cc_sf=0, cc_of=0, cc_cf=0.
  - M register = NOP bubble: M_stat=AOK(1), M_icode=1, M_cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE.
- CC update, on posedge clk:
  - Condition: E_icode==6 (OPq), exc_block==0, M_stall==0, and E_stat==AOK.
  - ZF = (alu_out==0). SF = alu_out[W-1]. OF = alu_overflow_check. CF = alu_carry_out.
  - Otherwise the CC hold their value.
- e_cnd, combinational from the registered CC (the pre-update value in the same cycle):
  - SF^OF is the signed "less" term.
  - ifun 0: 1 (always)
  - ifun 1: (SF^OF)|ZF (le)
  - ifun 2: SF^OF (l)
  - ifun 3: ZF (e)
  - ifun 4: !ZF (ne)
  - ifun 5: !(SF^OF) (ge)
  - ifun 6: !(SF^OF)&!ZF (g)
  - ifun 7-15: 0
  - e_cnd is meaningful only for icode 2 (cmov) and 7 (jXX). For any other icode it is still driven per the table.
- e_dstE = RNONE when E_icode==2 and e_cnd==0; otherwise E_dstE.
- M register, on posedge clk:
  - M_stall=1: hold all fields. Stall wins if both stall and bubble are high.
  - M_bubble=1 (no stall): load the reset NOP values.
  - Else: load E_stat, E_icode, e_cnd, alu_out, E_valA, e_dstE, E_dstM.
- Latency:
  - CC: 1 cycle after an OPq sits in E.
  - M fields: 1 cycle.
  - e_cnd, e_dstE: 0 cycles (combinational).
- Boundaries:
  - An OPq is immediately followed by jXX. The jXX sees the new CC because it evaluates one cycle later.
  - An OPq in E while exc_block=1: the CC are frozen even though the M register still loads.
  - Reset asserted mid-stall: reset overrides and clears to the NOP state.
  - alu_out = 64'h8000_0000_0000_0000: SF=1, ZF=0.

Decomposition:
- Shared package y86_pkg:
  - icode constants: INOP=1, ICMOV=2, IOPQ=6, IJXX=7.
  - Condition-function constants C_ALWAYS..C_G (0-6).
  - Stat codes: AOK=1, HLT=2, ADR=3, INS=4.
  - RNONE.
- One natural sub-module, cond_eval: pure combinational (ifun, zf, sf, of) -> cnd. It is reused by the decode-stage branch predictor checks.

Test Plan:
- Reset check: assert rst with no clock -> cc_zf=1, cc_sf=0, cc_of=0, M_icode=1, M_dstE=4'hF, M_stat=1.
- OPq result 0, then flag tracking:
  - OPq with alu_out=0, overflow=0 -> next cycle ZF=1, SF=0.
  - Then jXX ifun=3 -> e_cnd=1.
  - Then OPq with alu_out=64'hFFFF_FFFF_FFFF_FFFF, overflow=1 -> SF=1, OF=1, so ifun=2 (l) gives e_cnd=0 and ifun=5 gives e_cnd=1.
- cmov squash: CC ZF=0, E_icode=2, E_ifun=3, E_dstE=4'h3 -> e_dstE=4'hF, and next cycle M_dstE=4'hF, M_cnd=0. With ifun=4 -> M_dstE=4'h3.
- Exception blocking: OPq with alu_out=0 and exc_block=1 -> CC unchanged, M_valE=0 loaded. Same with E_stat=HLT(2) -> CC unchanged.
- Stall and bubble: M_stall=1 for 2 cycles -> M fields hold. M_bubble=1 -> M_icode=1, M_dstE=F. Stall and bubble together -> hold.
- Async reset mid-operation: rst pulsed between clock edges while M holds OPq data -> M and CC clear immediately, without waiting for a clock edge.
